seq_detector_param: RTL
=======================

# seq_detector_param

Parametrised serial pattern detector. It samples one input bit per enabled clock and compares the last N bits against a programmable N-bit pattern. It drives a Mealy-style match output and a Moore-style match output at the same time, and supports overlapping and non-overlapping detection. It supersedes the fixed 10010 Moore/Mealy detector pair and is the detector instantiated by the serial-input front ends.

## Interface
Parameters:
- N, 5, pattern length in bits (N ≥ 2).
- PATTERN, 5'b10010, pattern register reset value, N bits. The MSB is the first bit received.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = history restarts after each match.
- CNT_W, 8, match counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  sample enable. `j` is consumed on a rising edge only when en=1.
- j  in  1  serial data bit.
- load  in  1  load `pat_in` into the pattern register.
- pat_in  in  N  new pattern, MSB first.
- mealy  out  1  combinational match, valid in the cycle the last pattern bit is presented.
- moore  out  1  registered match, high for exactly one cycle after the matching sample edge.
- match_cnt  out  CNT_W  saturating count of matches (see Configuration).

## Operation
State registers:
- pat[N-1:0]: the pattern.
- hist[N-1:0]: shift history. The newest bit is in the LSB.
- fill: number of valid history bits, 0..N, saturates at N. Width is clog2(N+1).
- moore: the registered Moore output.
- match_cnt: the match counter.

Reset (rst=0, asynchronous):
- pat=PATTERN, hist=0, fill=0.
- moore=0, match_cnt=0.
- mealy=0 follows combinationally.

Combinational hit:
- hit = en & !load & (fill ≥ N-1) & ({hist[N-2:0], j} == pat).
- mealy = hit.

Sample edge with en=1 and load=0:
- hist ← {hist[N-2:0], j}.
- fill ← min(fill+1, N).
- If hit and OVERLAP=0, fill ← 0 instead. hist still shifts.

Load edge (load=1, en is don't-care):
- pat ← pat_in, hist ← 0, fill ← 0.
- The `j` bit on that edge is discarded and no match is produced.

Idle edge (en=0, load=0):
- hist, fill and pat hold.

Moore output and counter, on every edge:
- moore ← hit.
- If hit, match_cnt ← match_cnt+1, saturating at 2^CNT_W−1.

The Moore/Mealy mode is implicit: both outputs always exist, and moore equals mealy delayed by one clock.

## Timing
- mealy has zero latency. It is combinational from j/en/load and is not glitch-filtered, so sample it at the clock edge.
- moore has a latency of one clock after the edge that consumed the last pattern bit. It is high for one cycle per match.
- Back-to-back matches are possible only with OVERLAP=1 and a self-overlapping pattern. moore then pulses once per matching edge and can be high on consecutive cycles for patterns such as all-ones.
- First possible match: the N-th enabled sample after reset, load, or a non-overlap match.
- Reset mid-stream: outputs clear immediately and the partial history is lost.
- Gaps in en do not break the sequence. Enabled samples are contiguous by definition.
- load and a would-be match on the same edge: load wins, no match, and the counter is unchanged.
- match_cnt at saturation: it holds the all-ones value, while moore and mealy still pulse.

## Configuration
- SEQDET_MATCH_CNT_EN defined: the match counter is implemented as described.
- SEQDET_MATCH_CNT_EN undefined: no counter register is built, match_cnt is tied to 0, and all other behaviour is identical.

## Test plan
1. Overlap match. N=5, PATTERN=10010, OVERLAP=1. Apply en=1 and the stream 1,0,0,1,0,0,1,0 after reset.
   - mealy is high during bits 5 and 8.
   - moore is high in the cycles after edges 5 and 8.
   - match_cnt=2.
2. Non-overlap. The same stream with OVERLAP=0.
   - Only one match, at bit 5, and match_cnt=1.
   - Appending 0,1,0 (total 10010010010) gives a second match at bit 11.
3. Enable gaps. Interleave en=0 cycles between every bit of 1,0,0,1,0 with random j during the gaps.
   - Exactly one match, on the edge of the 5th enabled bit.
4. Runtime load. Load pat_in=11011, then stream 1,1,0,1,1,0,1,1.
   - Matches at bits 5 and 8 (overlap).
   - Asserting load on the same edge as the last bit of a would-be 10010 match produces no mealy, moore or counter change.
5. Async reset. Drop rst mid-pattern after 1,0,0,1 while mealy would be high.
   - All outputs go to 0 before the next edge.
   - After release, 0 alone does not match and a full 10010 is required.
6. Counter saturation. CNT_W=2 with 5 matches.
   - match_cnt reads 1,2,3,3,3 and moore pulses 5 times.
   - With the macro undefined, match_cnt stays 0 throughout.

Source files
------------

// File: rtl/seq_detector_param.sv
// seq_detector_param
// Serial pattern detector. It compares the last N enabled samples of j against
// a pattern register that can be reloaded at run time.
// Outputs:
//   - mealy: combinational match, asserted in the cycle the final bit is presented.
//   - moore: the same match, registered one clock later.
// Overlapping or restarting detection is chosen with OVERLAP.
// Optional feature macro: SEQDET_MATCH_CNT_EN.
//   - Defined: builds the saturating match counter.
//   - Undefined: match_cnt is tied to zero.
module seq_detector_param #(
   parameter int             N       = 5,
   parameter logic [N-1:0]   PATTERN = 5'b10010,
   parameter bit             OVERLAP = 1'b1,
   parameter int             CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             j,
   input  logic             load,
   input  logic [N-1:0]     pat_in,
   output logic             mealy,
   output logic             moore,
   output logic [CNT_W-1:0] match_cnt
);

   localparam int                FILL_W    = $clog2(N + 1);
   localparam logic [FILL_W-1:0] FILL_MIN  = FILL_W'(N - 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);

   logic [N-1:0]      pat_q, pat_d;
   logic [N-1:0]      hist_q, hist_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic              moore_q, moore_d;
   logic [N-1:0]      window;
   logic              hit;

   // Candidate window and match: the N-1 most recent samples plus the bit on j now
   always_comb begin
      window = {hist_q[N-2:0], j};
      hit    = en & ~load & (fill_q >= FILL_MIN) & (window == pat_q);
   end

   assign mealy = hit;
   assign moore = moore_q;

   // Next-state: load clears the history, an enabled sample shifts it in, otherwise hold
   always_comb begin
      pat_d   = pat_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      moore_d = hit;
      if (load) begin
         pat_d  = pat_in;
         hist_d = '0;
         fill_d = '0;
      end else if (en) begin
         hist_d = window;
         if (fill_q != FILL_FULL) begin
            fill_d = fill_q + 1'b1;
         end
         // Without overlap the bits of a match cannot start the next one
         if (hit && !OVERLAP) begin
            fill_d = '0;
         end
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pat_q   <= PATTERN;
         hist_q  <= '0;
         fill_q  <= '0;
         moore_q <= 1'b0;
      end else begin
         pat_q   <= pat_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         moore_q <= moore_d;
      end
   end

`ifdef SEQDET_MATCH_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Match counter: increments on every hit and holds once it reaches all-ones
   always_comb begin
      cnt_d = cnt_q;
      if (hit && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign match_cnt = cnt_q;
`else
   assign match_cnt = '0;
`endif

endmodule
